sprite_draw_ctrl: RTL and testbench
===================================

// Module: sprite_draw_ctrl
// PURPOSE
//  Sequences one 16x16 sprite blit at a time. Accepts a draw request (x, y, sprite index) and drives
//  the sprite table index. Walks the returned 16x16x3-bit bitmap row-major, one pixel per cycle,
//  and emits frame-buffer pixel writes, skipping transparent and off-screen pixels.
//  Sits between game/maze logic (requester) and the frame-buffer write port.
// PARAMETERS
//  SCREEN_W     640   visible width in pixels; pixels with x >= SCREEN_W are clipped
//  SCREEN_H     480   visible height in pixels; pixels with y >= SCREEN_H are clipped
//  XW           10    width of x coordinates
//  YW           10    width of y coordinates
//  TRANSPARENT  3'd7  colour code that is never written
// PORTS
//  Clk         in   1        system clock; all state on rising edge
//  Reset       in   1        asynchronous, active-high reset
//  req_valid   in   1        draw request present
//  req_ready   out  1        controller can accept a request (IDLE only)
//  req_x       in   XW       screen x of sprite column 0
//  req_y       in   YW       screen y of sprite row 0
//  req_sprite  in   3        sprite index to draw
//  tbl_index   out  3        index driven to sprite table, registered
//  tbl_sprite  in   16x16x3  table output: [row][15:0][2:0]; element [15] is leftmost pixel
//  fb_we       out  1        pixel write strobe
//  fb_x        out  XW       pixel x
//  fb_y        out  YW       pixel y
//  fb_color    out  3        pixel colour code
//  fb_ready    in   1        frame buffer accepts the write this cycle
//  busy        out  1        high from accept until DONE inclusive
//  done        out  1        one-cycle pulse when blit completes
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, row=col=0, tbl_index=0. Outputs: fb_we=0, fb_x=0, fb_y=0,
//    fb_color=0, busy=0, done=0, req_ready=1 once Reset deasserts.
//  - States: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
//  - IDLE: req_ready=1. On req_valid & req_ready, latch x, y and sprite into tbl_index;
//    set row=col=0 and go to LOAD.
//  - LOAD: one settle cycle so tbl_sprite reflects the new tbl_index. No fb_we. Go to DRAW.
//  - DRAW: current pixel p = tbl_sprite[row][15-col]; pixel position px = x+col, py = y+row.
//    - Sums computed at XW+1 / YW+1 bits: no wrap, carry-out means off-screen.
//    - Pixel is writable iff p != TRANSPARENT, px < SCREEN_W and py < SCREEN_H.
//    - Writable pixel: fb_we=1, fb_x=px, fb_y=py, fb_color=p.
//      Hold all four signals stable until fb_ready=1, then advance.
//    - Non-writable pixel: fb_we=0; advance next cycle; fb_ready ignored.
//    - Advance: col+1; at col=15, col=0 and row+1; at row=15,col=15 go to DONE.
//  - DONE: done=1 for exactly one cycle, fb_we=0, then IDLE.
//  - Latency: accept->first pixel = 2 cycles. Full opaque blit with fb_ready=1: 256 DRAW cycles,
//    so done arrives 258 cycles after accept.
//  - req_ready=0 outside IDLE. Requests in other states are not latched; the requester holds req_valid.
//  - tbl_index stays constant from accept until the next accept.
//  - Simultaneous done and new req_valid: the request is accepted on the following IDLE cycle.
//  - Reset mid-blit: fb_we drops immediately and the blit is abandoned; done is not pulsed.
// STRUCTURE
//  - sprite_pkg (shared): SPRITE_DIM=16, typedef logic [2:0] color_t,
//    typedef color_t [15:0] sprite_row_t, typedef sprite_row_t sprite_t [15:0],
//    TRANSPARENT, state_t enum {IDLE, LOAD, DRAW, DONE}.
//  - Sub-module sprite_pixel_counter: 4-bit row/col counter with advance, clear and last outputs.
//  - Clip/transparency test and FSM stay in this module.
// TESTING
//  1. Reset mid-DRAW with fb_we=1 -> fb_we=0, busy=0 in the same cycle; later request runs full blit.
//  2. Sprite 0 at (100,50), fb_ready=1 -> writes only non-7 pixels;
//     row 0 writes x=105..110 at y=50 with colour 3; done at accept+258.
//  3. Sprite 0 at (630,475) -> no write with fb_x>=640 or fb_y>=480; blit still takes 256 DRAW cycles.
//  4. fb_ready held 0 for 5 cycles on first opaque pixel -> fb_we, fb_x, fb_y, fb_color stable
//     for those 5 cycles; no pixel skipped.
//  5. Index 3 (table default, all 0) at (0,0) -> 256 writes of colour 0 covering (0..15, 0..15).
//  6. req_valid asserted during DRAW -> req_ready=0; request accepted 1 cycle after done pulse.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types for the sprite blitter: bitmap layout, colour code and controller states.
package sprite_pkg;
    localparam int SPRITE_DIM = 16;

    typedef logic [2:0] color_t;
    typedef color_t [15:0] sprite_row_t;
    typedef sprite_row_t sprite_t [15:0];

    localparam color_t TRANSPARENT = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
endpackage

// File: rtl/sprite_pixel_counter.sv
// Row-major 16x16 pixel walker; col wraps into row, last flags the final pixel.
module sprite_pixel_counter import sprite_pkg::*; (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clear_i,
    input  logic       advance_i,
    output logic [3:0] row_o,
    output logic [3:0] col_o,
    output logic       last_o
);
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            col_d = col_q + 4'd1;
            if (col_q == 4'(SPRITE_DIM - 1))
                row_d = row_q + 4'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == 4'(SPRITE_DIM - 1)) && (col_q == 4'(SPRITE_DIM - 1));
endmodule

// File: rtl/sprite_draw_ctrl.sv
// One-at-a-time 16x16 sprite blit: latches a request, walks the bitmap and emits
// clipped, non-transparent frame-buffer writes with a ready handshake.
module sprite_draw_ctrl import sprite_pkg::*; #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [XW-1:0] req_x,
    input  logic [YW-1:0] req_y,
    input  logic [2:0]    req_sprite,
    output logic [2:0]    tbl_index,
    input  sprite_t       tbl_sprite,
    output logic          fb_we,
    output logic [XW-1:0] fb_x,
    output logic [YW-1:0] fb_y,
    output logic [2:0]    fb_color,
    input  logic          fb_ready,
    output logic          busy,
    output logic          done
);
    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    idx_q, idx_d;

    logic [3:0]    row, col;
    logic          last, adv, clr;
    color_t        pix;
    logic [XW:0]   px;
    logic [YW:0]   py;
    logic          writable;

    sprite_pixel_counter u_cnt (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear_i   (clr),
        .advance_i (adv),
        .row_o     (row),
        .col_o     (col),
        .last_o    (last)
    );

    // Element [15] is the leftmost pixel, so column 0 reads index 15.
    assign pix = tbl_sprite[row][4'd15 - col];
    // One extra bit so a carry-out lands off-screen instead of wrapping.
    assign px  = {1'b0, x_q} + {{(XW-3){1'b0}}, col};
    assign py  = {1'b0, y_q} + {{(YW-3){1'b0}}, row};

    assign writable = (state_q == DRAW) && (pix != TRANSPARENT) &&
                      (px < (XW+1)'(SCREEN_W)) && (py < (YW+1)'(SCREEN_H));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        clr     = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                x_d     = req_x;
                y_d     = req_y;
                idx_d   = req_sprite;
                clr     = 1'b1;
                state_d = LOAD;
            end
            LOAD: state_d = DRAW;
            DRAW: if (!writable || fb_ready) begin
                adv = 1'b1;
                if (last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !Reset;
    assign tbl_index = idx_q;
    assign fb_we     = writable;
    assign fb_x      = writable ? px[XW-1:0] : '0;
    assign fb_y      = writable ? py[YW-1:0] : '0;
    assign fb_color  = writable ? pix : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Directed bench: a bitmap model feeds the sprite table, expected writes go to a
// scoreboard queue at request time and are popped on each fb handshake.
module tb_sprite_draw_ctrl;
    import sprite_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] req_x = '0;
    logic [9:0] req_y = '0;
    logic [2:0] req_sprite = '0;
    logic [2:0] tbl_index;
    sprite_t    tbl_sprite;
    logic       fb_we;
    logic [9:0] fb_x;
    logic [9:0] fb_y;
    logic [2:0] fb_color;
    logic       fb_ready = 1'b1;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {int x; int y; int c;} wr_t;
    wr_t exp_q[$];

    sprite_draw_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_sprite(req_sprite),
        .tbl_index(tbl_index), .tbl_sprite(tbl_sprite),
        .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
        .fb_ready(fb_ready), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    // Table contents: 0 = band of colours 3..6 in cols 5..10 of rows 0..11,
    // 1 = fully opaque gradient, 2 = fully transparent, others all colour 0.
    function automatic color_t model_pix(int s, int r, int c);
        if (s == 0) return (c >= 5 && c <= 10 && r < 12) ? color_t'(3 + (r % 4)) : 3'd7;
        if (s == 1) return color_t'((r + c) % 7);
        if (s == 2) return 3'd7;
        return 3'd0;
    endfunction

    always_comb begin
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                tbl_sprite[r][15-c] = model_pix(int'(tbl_index), r, c);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_req(input int x, input int y, input int s);
        int t;
        wr_t w;
        exp_q.delete();
        @(negedge Clk);
        req_valid  = 1'b1;
        req_x      = 10'(x);
        req_y      = 10'(y);
        req_sprite = 3'(s);
        t = 0;
        while (!req_ready && t < 600) begin
            @(negedge Clk);
            t++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                w.x = x + c;
                w.y = y + r;
                w.c = int'(model_pix(s, r, c));
                if (w.c != 7 && w.x < 640 && w.y < 480) exp_q.push_back(w);
            end
    endtask

    task automatic run_blit(input int x, input int y, input int s, input int stall, input bit pend);
        int  cyc;
        int  stalls;
        int  stray;
        bit  seen_done;
        start_req(x, y, s);
        fb_ready  = 1'b1;
        cyc       = 0;
        stalls    = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 700) begin
            @(negedge Clk);
            cyc++;
            if (cyc == 1) req_valid = 1'b0;
            if (pend && cyc == 5) begin
                req_valid = 1'b1; req_x = '0; req_y = '0; req_sprite = 3'd2;
            end
            chk("busy_during", 32'(busy), 32'd1);
            chk("ready_low", 32'(req_ready), 32'd0);
            chk("tbl_index", 32'(tbl_index), 32'(s));
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    chk("stray_write", 32'd1, 32'd0);
                    fb_ready = 1'b1;
                end else begin
                    chk("fb_x", 32'(fb_x), 32'(exp_q[0].x));
                    chk("fb_y", 32'(fb_y), 32'(exp_q[0].y));
                    chk("fb_color", 32'(fb_color), 32'(exp_q[0].c));
                    if (stalls < stall) begin
                        fb_ready = 1'b0;
                        stalls++;
                    end else begin
                        fb_ready = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                fb_ready = 1'($urandom_range(0, 1));
            end
            if (done) seen_done = 1'b1;
        end
        chk("done_cycle", 32'(cyc), 32'(258 + stall));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge Clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
        if (pend) begin
            // Held request is taken on this IDLE cycle; next cycle is LOAD.
            @(negedge Clk);
            req_valid = 1'b0;
            chk("pend_busy", 32'(busy), 32'd1);
            chk("pend_ready", 32'(req_ready), 32'd0);
            chk("pend_index", 32'(tbl_index), 32'd2);
            cyc   = 1;
            stray = 0;
            while (!done && cyc < 700) begin
                @(negedge Clk);
                cyc++;
                if (fb_we) stray++;
            end
            chk("pend_done_cycle", 32'(cyc), 32'd258);
            chk("pend_no_writes", 32'(stray), 32'd0);
            @(negedge Clk);
        end
        fb_ready = 1'b1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_index", 32'(tbl_index), 32'd0);
        chk("rst_fb_x", 32'(fb_x), 32'd0);
        chk("rst_fb_y", 32'(fb_y), 32'd0);
        chk("rst_fb_color", 32'(fb_color), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of DRAW while writing
        start_req(0, 0, 1);
        fb_ready = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            req_valid = 1'b0;
        end
        chk("mid_fb_we", 32'(fb_we), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_fb_we", 32'(fb_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        exp_q.delete();
        run_blit(0, 0, 1, 0, 1'b0);

        // Band sprite in the middle of the screen
        run_blit(100, 50, 0, 0, 1'b0);
        // Clipping at the bottom-right corner
        run_blit(630, 475, 0, 0, 1'b0);
        // Back-pressure on the first opaque pixel
        run_blit(200, 100, 1, 5, 1'b0);
        // Default table entry: full 16x16 of colour 0
        run_blit(0, 0, 3, 0, 1'b0);
        // Request held during DRAW is accepted right after done
        run_blit(300, 200, 1, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
